// File: rtl/fitbit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fitbit_pkg : shared constants and helpers for the step-rate front end
// Rev 1.0
// ---------------------------------------------------------------------------
package fitbit_pkg;

   localparam int STEP_TOTAL_W        = 14;
   localparam int STEP_TOTAL_MAX      = 9999;
   localparam int HIGH_THRESH_DEFAULT = 2;

   // Running total that sticks at the display limit instead of wrapping.
   function automatic logic [STEP_TOTAL_W-1:0] total_next(
      input logic [STEP_TOTAL_W-1:0] total,
      input logic                    evt
   );
      if (evt && (total != STEP_TOTAL_W'(STEP_TOTAL_MAX)))
         return total + STEP_TOTAL_W'(1);
      return total;
   endfunction

endpackage
`default_nettype wire

// File: rtl/step_edge_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// step_edge_conditioner : 2-flop sync, optional debounce (STEP_DEBOUNCE_EN),
// rising-edge detect producing a one-cycle step_evt per accepted step. Rev 1.0
// ---------------------------------------------------------------------------
module step_edge_conditioner
   import fitbit_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic step_in,
   output logic step_evt
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;
   logic evt_q,   evt_d;
   logic level;

   always_comb begin
      sync1_d = step_in;
      sync2_d = sync1_q;
   end

`ifdef STEP_DEBOUNCE_EN
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            stable_q, stable_d;

   // Counts consecutive samples that disagree with the accepted level.
   always_comb begin
      db_cnt_d = '0;
      stable_d = stable_q;
      if (sync2_q != stable_q) begin
         if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1))
            stable_d = sync2_q;
         else
            db_cnt_d = db_cnt_q + DB_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_cnt_q <= '0;
         stable_q <= 1'b0;
      end else begin
         db_cnt_q <= db_cnt_d;
         stable_q <= stable_d;
      end
   end

   assign level = stable_q;
`else
   // Debounce length has no effect in this build.
   if (DEBOUNCE_CYCLES < 1) begin : g_db_unused
   end

   assign level = sync2_q;
`endif

   always_comb begin
      prev_d = level;
      evt_d  = level & ~prev_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         evt_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         evt_q   <= evt_d;
      end
   end

   assign step_evt = evt_q;

endmodule
`default_nettype wire

// File: rtl/step_rate_classifier.sv
`default_nettype none
// ---------------------------------------------------------------------------
// step_rate_classifier : per-second step window, high-activity flag, rate and
// saturating total. Optional debounce via STEP_DEBOUNCE_EN. Rev 1.0
// ---------------------------------------------------------------------------
module step_rate_classifier
   import fitbit_pkg::*;
#(
   parameter int TICKS_PER_SEC   = 100000000,
   parameter int HIGH_THRESH     = HIGH_THRESH_DEFAULT,
   parameter int CNT_W           = 8,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    step_in,
   output logic                    high_activity,
   output logic [CNT_W-1:0]        steps_last_sec,
   output logic                    sec_tick,
   output logic [STEP_TOTAL_W-1:0] step_total
);

   localparam int WIN_W = $clog2(TICKS_PER_SEC);

   logic                    step_evt;
   logic                    terminal;
   logic [CNT_W-1:0]        win_inc;
   logic [WIN_W-1:0]        win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0]        win_steps_q, win_steps_d;
   logic [CNT_W-1:0]        steps_last_sec_q, steps_last_sec_d;
   logic                    high_q, high_d;
   logic [STEP_TOTAL_W-1:0] total_q, total_d;

   step_edge_conditioner #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_cond (
      .clk      (clk),
      .reset    (reset),
      .step_in  (step_in),
      .step_evt (step_evt)
   );

   always_comb begin
      terminal = (win_cnt_q == WIN_W'(TICKS_PER_SEC - 1));
      // A step landing on the terminal cycle belongs to the closing window.
      win_inc  = (step_evt && (win_steps_q != '1)) ? win_steps_q + CNT_W'(1) : win_steps_q;

      win_cnt_d        = terminal ? '0 : win_cnt_q + WIN_W'(1);
      win_steps_d      = win_inc;
      steps_last_sec_d = steps_last_sec_q;
      high_d           = high_q;
      if (terminal) begin
         win_steps_d      = '0;
         steps_last_sec_d = win_inc;
         high_d           = (32'(win_inc) >= HIGH_THRESH);
      end
      total_d = total_next(total_q, step_evt);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_cnt_q        <= '0;
         win_steps_q      <= '0;
         steps_last_sec_q <= '0;
         high_q           <= 1'b0;
         total_q          <= '0;
      end else begin
         win_cnt_q        <= win_cnt_d;
         win_steps_q      <= win_steps_d;
         steps_last_sec_q <= steps_last_sec_d;
         high_q           <= high_d;
         total_q          <= total_d;
      end
   end

   assign sec_tick       = terminal;
   assign high_activity  = high_q;
   assign steps_last_sec = steps_last_sec_q;
   assign step_total     = total_q;

endmodule
`default_nettype wire

// File: tb/tb_step_rate_classifier.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_step_rate_classifier : directed self-checking bench, 20-cycle windows.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_step_rate_classifier;

   localparam int TICKS = 20;
   localparam int CNT_W = 4;
   localparam int SAT_W = 3;
`ifdef STEP_DEBOUNCE_EN
   localparam int EVT_LAT         = 7;
   localparam int GLITCH_STEPS    = 0;
   localparam int PRE_RESET_TOTAL = 0;
`else
   localparam int EVT_LAT         = 3;
   localparam int GLITCH_STEPS    = 1;
   localparam int PRE_RESET_TOTAL = 1;
`endif

   logic             clk;
   logic             reset;
   logic             step_in;
   logic             high_activity, sec_tick;
   logic [CNT_W-1:0] steps_last_sec;
   logic [13:0]      step_total;
   logic             sat_high, sat_tick;
   logic [SAT_W-1:0] sat_last;
   logic [13:0]      sat_total;

   int n_cmp = 0;
   int n_bad = 0;

   step_rate_classifier #(
      .TICKS_PER_SEC (TICKS), .HIGH_THRESH (2), .CNT_W (CNT_W), .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk (clk), .reset (reset), .step_in (step_in),
      .high_activity (high_activity), .steps_last_sec (steps_last_sec),
      .sec_tick (sec_tick), .step_total (step_total)
   );

   // Narrow counter instance so the per-window saturation is reachable.
   step_rate_classifier #(
      .TICKS_PER_SEC (TICKS), .HIGH_THRESH (2), .CNT_W (SAT_W), .DEBOUNCE_CYCLES (4)
   ) dut_sat (
      .clk (clk), .reset (reset), .step_in (step_in),
      .high_activity (sat_high), .steps_last_sec (sat_last),
      .sec_tick (sat_tick), .step_total (sat_total)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      reset   = 1'b1;
      step_in = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Called on a negedge at window cycle c; raises step_in at c, c+2, ...
   task automatic step_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         step_in = 1'b1;
         @(negedge clk);
         step_in = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic wait_tick();
      bit seen = 1'b0;
      for (int i = 0; i < 2*TICKS && !seen; i++) begin
         @(negedge clk);
         seen = (sec_tick === 1'b1);
      end
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL wait_tick: sec_tick=0 for %0d cycles, required 1", 2*TICKS);
      end
   endtask

   task automatic test_reset();
      int cyc = 0;
      reset   = 1'b1;
      step_in = 1'b0;
      #3;
      n_cmp++; if (high_activity !== 1'b0) begin n_bad++; $display("FAIL reset_high: got %b, required 0", high_activity); end
      n_cmp++; if (steps_last_sec !== '0) begin n_bad++; $display("FAIL reset_rate: got %0d, required 0", steps_last_sec); end
      n_cmp++; if (step_total !== 14'd0) begin n_bad++; $display("FAIL reset_total: got %0d, required 0", step_total); end
      n_cmp++; if (sec_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b, required 0", sec_tick); end
      @(negedge clk);
      reset   = 1'b0;
      step_in = 1'b1;
      repeat (7) @(negedge clk);
      n_cmp++; if (step_total !== 14'(PRE_RESET_TOTAL)) begin n_bad++; $display("FAIL pre_reset_total: got %0d, required %0d", step_total, PRE_RESET_TOTAL); end
      #2;
      reset   = 1'b1;
      step_in = 1'b0;
      #1;
      n_cmp++; if (step_total !== 14'd0 || high_activity !== 1'b0 || steps_last_sec !== '0 || sec_tick !== 1'b0)
         begin n_bad++; $display("FAIL midwin_reset: total=%0d high=%b rate=%0d tick=%b, required all 0", step_total, high_activity, steps_last_sec, sec_tick); end
      n_cmp++; if (sat_total !== 14'd0 || sat_last !== '0) begin n_bad++; $display("FAIL midwin_reset_sat: total=%0d rate=%0d, required 0", sat_total, sat_last); end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 1; i <= 2*TICKS && cyc == 0; i++) begin
         @(negedge clk);
         if (sec_tick === 1'b1) cyc = i + 1;
      end
      n_cmp++; if (cyc !== TICKS) begin n_bad++; $display("FAIL first_window_len: got %0d cycles, required %0d", cyc, TICKS); end
      @(negedge clk);
      n_cmp++; if (steps_last_sec !== '0 || high_activity !== 1'b0) begin n_bad++; $display("FAIL partial_discard: rate=%0d high=%b, required 0 0", steps_last_sec, high_activity); end
   endtask

   task automatic test_rate_threshold();
      step_pulses(3);
      wait_tick();
      @(negedge clk);
      n_cmp++; if (steps_last_sec !== 4'd3) begin n_bad++; $display("FAIL rate_w1: got %0d, required 3", steps_last_sec); end
      n_cmp++; if (high_activity !== 1'b1) begin n_bad++; $display("FAIL high_w1: got %b, required 1", high_activity); end
      step_pulses(1);
      wait_tick();
      n_cmp++; if (high_activity !== 1'b1) begin n_bad++; $display("FAIL high_hold: got %b, required 1", high_activity); end
      @(negedge clk);
      n_cmp++; if (steps_last_sec !== 4'd1) begin n_bad++; $display("FAIL rate_w2: got %0d, required 1", steps_last_sec); end
      n_cmp++; if (high_activity !== 1'b0) begin n_bad++; $display("FAIL high_w2: got %b, required 0", high_activity); end
   endtask

   task automatic test_boundary();
      step_pulses(1);
      repeat (14) @(negedge clk);
      step_pulses(1);
      @(negedge clk);
      n_cmp++; if (sec_tick !== 1'b1 || dut.step_evt !== 1'b1) begin n_bad++; $display("FAIL bnd_coincide: tick=%b evt=%b, required 1 1", sec_tick, dut.step_evt); end
      @(negedge clk);
      n_cmp++; if (steps_last_sec !== 4'd2 || high_activity !== 1'b1) begin n_bad++; $display("FAIL bnd_close: rate=%0d high=%b, required 2 1", steps_last_sec, high_activity); end
      wait_tick();
      @(negedge clk);
      n_cmp++; if (steps_last_sec !== 4'd0 || high_activity !== 1'b0) begin n_bad++; $display("FAIL bnd_next: rate=%0d high=%b, required 0 0", steps_last_sec, high_activity); end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int w = 0; w < 2; w++) begin
         step_pulses(9);
         wait_tick();
         @(negedge clk);
         n_cmp++; if (steps_last_sec !== 4'd9) begin n_bad++; $display("FAIL sat_rate_w%0d: got %0d, required 9", w, steps_last_sec); end
         n_cmp++; if (sat_last !== 3'd7 || sat_high !== 1'b1) begin n_bad++; $display("FAIL sat_clip_w%0d: rate=%0d high=%b, required 7 1", w, sat_last, sat_high); end
      end
      step_pulses(2);
      wait_tick();
      @(negedge clk);
      n_cmp++; if (steps_last_sec !== 4'd2) begin n_bad++; $display("FAIL sat_rate_w2: got %0d, required 2", steps_last_sec); end
      n_cmp++; if (step_total !== 14'd20 || sat_total !== 14'd20) begin n_bad++; $display("FAIL sat_total: got %0d/%0d, required 20", step_total, sat_total); end
   endtask

   task automatic test_total_saturation();
      do_reset();
      for (int w = 0; w < 1111; w++) begin
         step_pulses(9);
         wait_tick();
         @(negedge clk);
      end
      n_cmp++; if (step_total !== 14'd9999 || sat_total !== 14'd9999) begin n_bad++; $display("FAIL total_reach: got %0d/%0d, required 9999", step_total, sat_total); end
      step_pulses(6);
      wait_tick();
      @(negedge clk);
      n_cmp++; if (step_total !== 14'd9999) begin n_bad++; $display("FAIL total_hold: got %0d, required 9999", step_total); end
      n_cmp++; if (steps_last_sec !== 4'd6 || high_activity !== 1'b1) begin n_bad++; $display("FAIL total_rate_hi: rate=%0d high=%b, required 6 1", steps_last_sec, high_activity); end
      step_pulses(1);
      wait_tick();
      @(negedge clk);
      n_cmp++; if (steps_last_sec !== 4'd1 || high_activity !== 1'b0 || step_total !== 14'd9999)
         begin n_bad++; $display("FAIL total_rate_lo: rate=%0d high=%b total=%0d, required 1 0 9999", steps_last_sec, high_activity, step_total); end
   endtask

   task automatic test_debounce();
      int evts = 0;
      int lat  = 0;
      do_reset();
      step_in = 1'b1;
      for (int i = 1; i <= 18; i++) begin
         @(negedge clk);
         if (i == 3) step_in = 1'b0;
         if (dut.step_evt === 1'b1) evts++;
      end
      n_cmp++; if (evts !== GLITCH_STEPS || step_total !== 14'(GLITCH_STEPS)) begin n_bad++; $display("FAIL glitch: evts=%0d total=%0d, required %0d", evts, step_total, GLITCH_STEPS); end
      evts    = 0;
      step_in = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 6) step_in = 1'b0;
         if (dut.step_evt === 1'b1) begin
            evts++;
            if (lat == 0) lat = i;
         end
      end
      n_cmp++; if (lat !== EVT_LAT) begin n_bad++; $display("FAIL pulse_latency: got %0d, required %0d", lat, EVT_LAT); end
      n_cmp++; if (evts !== 1 || step_total !== 14'(GLITCH_STEPS + 1)) begin n_bad++; $display("FAIL pulse_count: evts=%0d total=%0d, required 1 %0d", evts, step_total, GLITCH_STEPS + 1); end
   endtask

   initial begin
      test_reset();
`ifndef STEP_DEBOUNCE_EN
      test_rate_threshold();
      test_boundary();
      test_saturation();
      test_total_saturation();
`endif
      test_debounce();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
